// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the register-file read ports and the multiply/divide unit.
// The core side (master) drives the request; the unit (slave) returns status and HI/LO.
interface mul_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] operandA;
   logic [WIDTH-1:0] operandB;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, operandA, operandB,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, operandA, operandB,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO registers.
// Magnitude arithmetic over WIDTH iterations, signs applied in a single FINISH cycle.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input logic            clk,
   input logic            rst,
   mul_div_unit_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t             state_q, state_d;
   logic               is_div_q, is_div_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               dbz_q, dbz_d;
   logic [WIDTH-1:0]   b_mag_q, b_mag_d;
   logic [WIDTH-1:0]   orig_a_q, orig_a_d;
   logic [2*WIDTH:0]   work_q, work_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               in_signed, in_div, sign_a, sign_b;
   logic [WIDTH-1:0]   a_mag_in, b_mag_in;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH:0]   mul_next;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH+1:0]   div_diff;
   logic               div_ge;
   logic [2*WIDTH:0]   div_next;
   logic [2*WIDTH-1:0] prod_mag, prod_fin;
   logic [WIDTH-1:0]   quo_fin, rem_fin;

   assign in_signed = ~bus.op[0];
   assign in_div    = bus.op[1];
   assign sign_a    = in_signed & bus.operandA[WIDTH-1];
   assign sign_b    = in_signed & bus.operandB[WIDTH-1];
   assign a_mag_in  = sign_a ? (~bus.operandA + 1'b1) : bus.operandA;
   assign b_mag_in  = sign_b ? (~bus.operandB + 1'b1) : bus.operandB;

   // Multiply: {carry, upper, lower} accumulator, lower half holds the remaining multiplier bits.
   assign mul_sum  = work_q[2*WIDTH:WIDTH] + (work_q[0] ? {1'b0, b_mag_q} : '0);
   assign mul_next = {1'b0, mul_sum, work_q[WIDTH-1:1]};

   // Divide: {remainder(W+1), quotient/dividend(W)}, restoring step.
   assign div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
   assign div_diff  = {1'b0, div_shift} - {2'b00, b_mag_q};
   assign div_ge    = ~div_diff[WIDTH+1];
   assign div_next  = {(div_ge ? div_diff[WIDTH:0] : div_shift), work_q[WIDTH-2:0], div_ge};

   assign prod_mag = work_q[2*WIDTH-1:0];
   assign prod_fin = neg_res_q ? (~prod_mag + 1'b1) : prod_mag;
   assign quo_fin  = neg_res_q ? (~work_q[WIDTH-1:0] + 1'b1) : work_q[WIDTH-1:0];
   assign rem_fin  = neg_rem_q ? (~work_q[2*WIDTH-1:WIDTH] + 1'b1) : work_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d   = state_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dbz_d     = dbz_q;
      b_mag_d   = b_mag_q;
      orig_a_d  = orig_a_q;
      work_d    = work_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               is_div_d  = in_div;
               neg_res_d = sign_a ^ sign_b;
               neg_rem_d = sign_a;
               dbz_d     = in_div && (bus.operandB == '0);
               b_mag_d   = b_mag_in;
               orig_a_d  = bus.operandA;
               work_d    = {{(WIDTH+1){1'b0}}, a_mag_in};
               cnt_d     = '0;
               busy_d    = 1'b1;
               state_d   = CALC;
            end
         end
         CALC: begin
            work_d = is_div_q ? div_next : mul_next;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            if (!is_div_q) begin
               hi_d = prod_fin[2*WIDTH-1:WIDTH];
               lo_d = prod_fin[WIDTH-1:0];
            end else if (dbz_q) begin
               // Divide by zero returns the untouched dividend, not its magnitude.
               hi_d = orig_a_q;
               lo_d = '1;
            end else begin
               hi_d = rem_fin;
               lo_d = quo_fin;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         b_mag_q   <= '0;
         orig_a_q  <= '0;
         work_q    <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dbz_q     <= dbz_d;
         b_mag_q   <= b_mag_d;
         orig_a_q  <= orig_a_d;
         work_q    <= work_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit sitting directly downstream of the register file's two read ports in the SiliCore core. It takes `readData1`/`readData2` as operands for MULT/MULTU/DIV/DIVU, computes over a fixed number of cycles, and holds the result in architectural HI/LO registers. The core's MFHI/MFLO path later routes HI/LO back to the register file's `writeData`. `busy` stalls the fetch/decode stage while an operation is in flight.

## Interface
- `WIDTH`, 32: operand and HI/LO width; also the iteration count.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `operandA`  in  WIDTH  rs value / dividend, driven from `readData1`.
- `operandB`  in  WIDTH  rt value / divisor, driven from `readData2`.
- `busy`  out  1  high from the accept edge until the result edge, inclusive of FINISH.
- `done`  out  1  one-cycle pulse; HI/LO are valid and updated.
- `hi`  out  WIDTH  HI register: product upper half, or remainder.
- `lo`  out  WIDTH  LO register: product lower half, or quotient.

## Operation
- States: IDLE, CALC, FINISH.
- IDLE and `start`=1 at an edge:
  - Latch `op`.
  - Latch operand magnitudes. Signed ops take the absolute value; unsigned ops take the raw value.
  - Latch the result-sign flags:
    - product sign = signA XOR signB;
    - quotient sign = signA XOR signB;
    - remainder sign = signA.
  - Latch the divide-by-zero flag (divide op and `operandB`==0).
  - Clear the iteration counter. Go to CALC.
- CALC: one iteration per edge.
  - Multiply: shift-add on a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract with quotient/remainder registers.
  - After iteration WIDTH, go to FINISH.
- FINISH (one edge):
  - Apply two's-complement negation per the sign flags.
  - Write `hi`/`lo`, pulse `done`, go to IDLE.
- Divide by zero:
  - Iterations still run, so latency is unchanged.
  - FINISH writes `lo`=all ones and `hi`=the original `operandA` (not its magnitude), for both DIV and DIVU.
- Signed overflow: DIV of 0x80000000 by 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0. This follows naturally from magnitude arithmetic; no special case.
- `start` in CALC or FINISH: ignored, not queued. The core must hold `start` low while `busy`=1.
- `hi`/`lo` change only at the FINISH edge. Between operations they hold their value.
- `op` and the operands are not sampled after the accept edge, so the register file may change them freely.

## Timing
- Reset (`rst`=0, asynchronous):
  - state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - Counter, accumulators and flags are cleared.
- Reset mid-operation: the result is discarded, no `done` is produced, and HI/LO become 0.
- Accept edge E0:
  - `busy`=1 from after E0.
  - Iterations occur on edges E1..E_WIDTH.
  - FINISH edge is E_(WIDTH+1).
  - After E_(WIDTH+1): `done`=1 and new `hi`/`lo` are visible for exactly one cycle; `busy`=0 in the same cycle.
- Total latency from accept to result is WIDTH+1 edges (33 for WIDTH=32).
- A new `start` is accepted on the edge ending the `done` cycle, so back-to-back throughput is one operation per WIDTH+2 cycles.
- `busy` and `done` are registered outputs with no combinational path from `start`.

## Test plan
- Reset and idle:
  - Drive `rst`=0 mid-CALC of a MULTU.
  - Expect `busy`=0, `done`=0, `hi`=`lo`=0 immediately.
  - After release, expect no `done` pulse.
- MULTU:
  - 0xFFFFFFFF × 0xFFFFFFFF gives `hi`=0xFFFFFFFE, `lo`=0x00000001.
  - `done` appears exactly 33 edges after accept.
- MULT:
  - −7 × 6 gives `hi`=0xFFFFFFFF, `lo`=0xFFFFFFD6.
  - 0x80000000 × 0x80000000 gives `hi`=0x40000000, `lo`=0.
- DIV:
  - −7 / 2 gives `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1).
  - 7 / −2 gives `lo`=−3, `hi`=1.
  - 0x80000000 / −1 gives `lo`=0x80000000, `hi`=0.
- DIVU by zero:
  - 0x1234 / 0 gives `lo`=0xFFFFFFFF, `hi`=0x1234 with unchanged latency.
  - 100 / 7 gives `lo`=14, `hi`=2.
- Busy/restart:
  - Pulse `start` with new operands during CALC; it must be ignored and the first result must be unchanged.
  - A `start` in the `done` cycle is accepted, and its `done` follows 33 edges later.
